// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the fetch requester (imem) and the data requester (dmem).
// Each requester owns a one-deep pending slot. Slots are granted downstream one at a time:
// one ISSUE cycle that pulses the masks, then a WAIT state until mem_resp arrives.
// The response is routed back to the owning requester.
// Default arbitration gives dmem fixed priority. A starvation counter hands the port to imem
// after STARVE_LIMIT consecutive dmem grants made while imem was waiting.
// Define ARB_RR_EN to use round-robin arbitration (last-grant bit) instead.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] imem_addr,
  input  logic [3:0]  imem_rmask,
  output logic [31:0] imem_rdata,
  output logic        imem_resp,
  input  logic [31:0] dmem_addr,
  input  logic [3:0]  dmem_rmask,
  input  logic [3:0]  dmem_wmask,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_resp,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_rmask,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp
);

  typedef enum logic [1:0] {StIdle, StIssue, StWaitI, StWaitD} state_e;

  state_e      state_q, state_d;
  logic        gnt_d_q, gnt_d_d;  // 1: granted slot is dmem

  logic        i_pend_q, d_pend_q;
  logic [31:0] i_addr_q, d_addr_q, d_wdata_q;
  logic [3:0]  i_rmask_q, d_rmask_q, d_wmask_q;

  logic i_req, d_req, i_acc, d_acc, i_clr, d_clr;
  logic i_av, d_av, grant_evt, pick_d;

  assign i_req = |imem_rmask;
  assign d_req = |(dmem_rmask | dmem_wmask);
  // A slot stays full until its response, so a request against a full slot is dropped.
  assign i_acc = i_req && !i_pend_q;
  assign d_acc = d_req && !d_pend_q;
  assign i_clr = (state_q == StWaitI) && mem_resp;
  assign d_clr = (state_q == StWaitD) && mem_resp;
  // Arbitration sees requests arriving this cycle, so a lone request issues on the next cycle.
  assign i_av  = i_pend_q || i_req;
  assign d_av  = d_pend_q || d_req;
  assign grant_evt = (state_q == StIdle) && (i_av || d_av);

`ifdef ARB_RR_EN
  logic last_d_q;  // 1: previous grant went to dmem

  // Both slots waiting: grant the requester that was not served last.
  always_comb begin
    pick_d = d_av && (!i_av || !last_d_q);
  end

  // Last-grant register; resets to imem so dmem wins the first tie.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_d_q <= 1'b0;
    end else if (grant_evt) begin
      last_d_q <= pick_d;
    end
  end
`else
  localparam logic [3:0] StarveLim = 4'(STARVE_LIMIT);
  logic [3:0] starve_cnt_q;

  // dmem wins ties unless imem has been passed over StarveLim times in a row.
  always_comb begin
    pick_d = d_av && (!i_av || (starve_cnt_q != StarveLim));
  end

  // Count dmem grants taken while imem waits; clear on an imem grant or when imem is idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt_q <= 4'd0;
    end else if (grant_evt) begin
      if (pick_d && i_av) begin
        if (starve_cnt_q != 4'hF) starve_cnt_q <= starve_cnt_q + 4'd1;
      end else begin
        starve_cnt_q <= 4'd0;
      end
    end else if (!i_pend_q) begin
      starve_cnt_q <= 4'd0;
    end
  end
`endif

  // Pending flags: set on capture, cleared when the owner's response arrives.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      i_pend_q <= 1'b0;
      d_pend_q <= 1'b0;
    end else begin
      if (i_clr) i_pend_q <= 1'b0;
      else if (i_acc) i_pend_q <= 1'b1;
      if (d_clr) d_pend_q <= 1'b0;
      else if (d_acc) d_pend_q <= 1'b1;
    end
  end

  // Slot payload, captured together with the request; meaningless while the slot is empty.
  always_ff @(posedge clk) begin
    if (i_acc) begin
      i_addr_q  <= imem_addr;
      i_rmask_q <= imem_rmask;
    end
    if (d_acc) begin
      d_addr_q  <= dmem_addr;
      d_rmask_q <= dmem_rmask;
      d_wmask_q <= dmem_wmask;
      d_wdata_q <= dmem_wdata;
    end
  end

  // State and grant registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      gnt_d_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_d_q <= gnt_d_d;
    end
  end

  // Next-state logic; the grant is latched on the IDLE->ISSUE edge.
  always_comb begin
    state_d = state_q;
    gnt_d_d = gnt_d_q;
    unique case (state_q)
      StIdle: begin
        if (grant_evt) begin
          state_d = StIssue;
          gnt_d_d = pick_d;
        end
      end
      StIssue: state_d = gnt_d_q ? StWaitD : StWaitI;
      StWaitI: if (mem_resp) state_d = StIdle;
      StWaitD: if (mem_resp) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Downstream drive: masks pulse only in ISSUE; address and data hold through WAIT.
  always_comb begin
    mem_addr  = gnt_d_q ? d_addr_q : i_addr_q;
    mem_wdata = d_wdata_q;
    mem_rmask = 4'h0;
    mem_wmask = 4'h0;
    if (state_q == StIssue) begin
      mem_rmask = gnt_d_q ? d_rmask_q : i_rmask_q;
      mem_wmask = gnt_d_q ? d_wmask_q : 4'h0;
    end
  end

  // Responses pass straight through to the owner; mem_resp outside WAIT is ignored.
  always_comb begin
    imem_resp  = (state_q == StWaitI) && mem_resp;
    dmem_resp  = (state_q == StWaitD) && mem_resp;
    imem_rdata = mem_rdata;
    dmem_rdata = mem_rdata;
  end

`ifndef SYNTHESIS
  a_imem_no_drop: assert property (@(posedge clk) disable iff (!rst_n) !(i_req && i_pend_q))
    else $error("imem request dropped: slot still busy");
  a_dmem_no_drop: assert property (@(posedge clk) disable iff (!rst_n) !(d_req && d_pend_q))
    else $error("dmem request dropped: slot still busy");
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter (STARVE_LIMIT=2). Per-requester queues hold expected
// transactions and a grant-order queue holds the expected owner of each downstream issue.
// A small memory responder answers each issue after the delay stored with the transaction.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  imem_rmask, dmem_rmask, dmem_wmask;
  logic        imem_resp, dmem_resp;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_rmask, mem_wmask;
  logic        mem_resp;

  always #5 clk = ~clk;

  mem_port_arbiter #(.STARVE_LIMIT(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_addr(imem_addr), .imem_rmask(imem_rmask), .imem_rdata(imem_rdata),
    .imem_resp(imem_resp),
    .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .mem_addr(mem_addr), .mem_rmask(mem_rmask), .mem_wmask(mem_wmask),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;
  } req_t;

  req_t i_q[$];
  req_t d_q[$];
  bit   gnt_q[$];  // expected owner of each issue, 1 = dmem

  int n_cmp = 0, n_err = 0, cyc = 0;
  int rsp_cnt = 0;
  logic [31:0] rsp_data;
  bit   force_resp = 0;
  bit   out_valid = 0, out_d = 0, out_read = 0;
  logic [31:0] out_rd;
  int   issue_cyc[2];
  int   resp_cyc[2];
  bit   saw_i_resp, saw_d_resp;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic clear_inputs();
    imem_rmask = 4'h0;
    dmem_rmask = 4'h0;
    dmem_wmask = 4'h0;
  endtask

  task automatic drive_i(input logic [31:0] addr, input logic [31:0] rdata, input int delay);
    req_t e;
    e.addr = addr; e.rmask = 4'hF; e.wmask = 4'h0; e.wdata = '0; e.rdata = rdata;
    e.delay = delay;
    i_q.push_back(e);
    imem_addr  = addr;
    imem_rmask = 4'hF;
  endtask

  task automatic drive_d(input logic [31:0] addr, input logic [3:0] rm, input logic [3:0] wm,
                         input logic [31:0] wd, input logic [31:0] rdata, input int delay);
    req_t e;
    e.addr = addr; e.rmask = rm; e.wmask = wm; e.wdata = wd; e.rdata = rdata;
    e.delay = delay;
    d_q.push_back(e);
    dmem_addr  = addr;
    dmem_rmask = rm;
    dmem_wmask = wm;
    dmem_wdata = wd;
  endtask

  // Sampled at the falling edge: checks issues against the scoreboard and routes responses.
  task automatic monitor();
    req_t e;
    bit   own_d;
    saw_i_resp = 0;
    saw_d_resp = 0;
    if (mem_rmask != 4'h0 || mem_wmask != 4'h0) begin
      if (gnt_q.size() == 0) begin
        check("spurious_issue", {mem_rmask, mem_wmask}, 8'h00);
      end else begin
        own_d = gnt_q.pop_front();
        if ((own_d ? d_q.size() : i_q.size()) == 0) begin
          check("issue_no_entry", 1, 0);
        end else begin
          e = own_d ? d_q.pop_front() : i_q.pop_front();
          check(own_d ? "d_addr" : "i_addr", mem_addr, e.addr);
          check(own_d ? "d_rmask" : "i_rmask", 32'(mem_rmask), 32'(e.rmask));
          check(own_d ? "d_wmask" : "i_wmask", 32'(mem_wmask), 32'(e.wmask));
          if (e.wmask != 4'h0) check("d_wdata", mem_wdata, e.wdata);
          out_valid = 1; out_d = own_d; out_read = (e.rmask != 4'h0); out_rd = e.rdata;
          rsp_cnt = e.delay; rsp_data = e.rdata;
          issue_cyc[own_d] = cyc;
        end
      end
    end
    if (mem_resp && out_valid) begin
      check("imem_resp_route", 32'(imem_resp), 32'(!out_d));
      check("dmem_resp_route", 32'(dmem_resp), 32'(out_d));
      if (out_read) check(out_d ? "dmem_rdata" : "imem_rdata",
                          out_d ? dmem_rdata : imem_rdata, out_rd);
      resp_cyc[out_d] = cyc;
      saw_i_resp = !out_d;
      saw_d_resp = out_d;
      out_valid = 0;
    end else if (imem_resp || dmem_resp) begin
      check("stray_resp", {imem_resp, dmem_resp}, 2'b00);
    end
  endtask

  // One clock: update the responder just after the edge, then sample at the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    mem_resp = 1'b0;
    if (force_resp) begin
      mem_resp = 1'b1;
      mem_rdata = 32'hBAD0BAD0;
      force_resp = 0;
    end else if (rsp_cnt == 1) begin
      mem_resp = 1'b1;
      mem_rdata = rsp_data;
      rsp_cnt = 0;
    end else if (rsp_cnt > 1) begin
      rsp_cnt--;
    end
    @(negedge clk);
    monitor();
  endtask

  // Run until the scoreboard drains; optionally re-request the cycle after each response.
  task automatic run(input int rr_d, input int rr_i, input int bound);
    int fire_d = 0, fire_i = 0, k = 0, nd = 0, ni = 0;
    while (k < bound && !(gnt_q.size() == 0 && !out_valid && rsp_cnt == 0 &&
                          fire_d == 0 && fire_i == 0)) begin
      if (fire_d == 1) begin
        drive_d(32'h4000 + 32'(nd * 4), 4'hF, 4'h0, '0, 32'hD0000000 + 32'(nd), 2);
        nd++;
      end
      if (fire_i == 1) begin
        drive_i(32'h8000 + 32'(ni * 4), 32'hA0000000 + 32'(ni), 2);
        ni++;
      end
      if (fire_d > 0) fire_d--;
      if (fire_i > 0) fire_i--;
      step();
      clear_inputs();
      if (saw_d_resp && rr_d > 0) begin fire_d = 2; rr_d--; end
      if (saw_i_resp && rr_i > 0) begin fire_i = 2; rr_i--; end
      k++;
    end
    if (k >= bound) check("run_timeout", 1, 0);
    step();
    step();
  endtask

  int req_cyc;

  initial begin
    rst_n = 1'b0;
    mem_resp = 1'b0;
    mem_rdata = '0;
    imem_addr = '0;
    dmem_addr = '0;
    dmem_wdata = '0;
    clear_inputs();
    @(negedge clk);
    step();
    step();
    check("rst_rmask", 32'(mem_rmask), 0);
    check("rst_wmask", 32'(mem_wmask), 0);
    check("rst_resp", {imem_resp, dmem_resp}, 2'b00);
    rst_n = 1'b1;
    step();

    // Lone fetch: mask pulse one cycle later, response three cycles after issue.
    gnt_q.push_back(0);
    drive_i(32'h1ECEB000, 32'h00000013, 3);
    req_cyc = cyc;
    step();
    clear_inputs();
    run(0, 0, 50);
    check("fetch_issue_lat", 32'(issue_cyc[0] - req_cyc), 1);
    check("fetch_resp_lat", 32'(resp_cyc[0] - issue_cyc[0]), 3);

    // Simultaneous fetch and load: dmem first, imem issues two cycles after dmem's response.
    gnt_q.push_back(1);
    gnt_q.push_back(0);
    drive_i(32'h1ECEB004, 32'h00100093, 2);
    drive_d(32'h00001000, 4'hF, 4'h0, '0, 32'hCAFE0001, 2);
    step();
    clear_inputs();
    run(0, 0, 50);
    check("imem_after_dmem", 32'(issue_cyc[0] - resp_cyc[1]), 2);

    // Store: write mask and data downstream, no read mask, dmem_resp on the minimum path.
    gnt_q.push_back(1);
    drive_d(32'h00002004, 4'h0, 4'h3, 32'hDEADBEEF, 32'h0, 1);
    step();
    clear_inputs();
    run(0, 0, 50);

    // Starvation: dmem re-requests right after each response while imem waits.
`ifdef ARB_RR_EN
    gnt_q.push_back(1); gnt_q.push_back(0); gnt_q.push_back(1);
    gnt_q.push_back(0); gnt_q.push_back(1);
`else
    gnt_q.push_back(1); gnt_q.push_back(1); gnt_q.push_back(0);
    gnt_q.push_back(1); gnt_q.push_back(0);
`endif
    drive_i(32'h1ECEB100, 32'h11111111, 2);
    drive_d(32'h00003100, 4'hF, 4'h0, '0, 32'h22222222, 2);
    step();
    clear_inputs();
    run(2, 1, 200);
    check("starve_all_granted", 32'(gnt_q.size() + i_q.size() + d_q.size()), 0);

    // Reset during WAIT_D, then a late mem_resp that must be ignored.
    gnt_q.push_back(1);
    drive_d(32'h00003000, 4'hF, 4'h0, '0, 32'h55555555, 3);
    step();
    clear_inputs();
    step();
    rst_n = 1'b0;
    out_valid = 0;
    step();
    rst_n = 1'b1;
    check("rst_wait_mask", {mem_rmask, mem_wmask}, 8'h00);
    step();
    check("late_resp_seen", 32'(mem_resp), 1);
    check("late_resp_ignored", {imem_resp, dmem_resp}, 2'b00);
    check("late_resp_mask", {mem_rmask, mem_wmask}, 8'h00);
    step();
    gnt_q.push_back(0);
    drive_i(32'h1ECEB200, 32'h33333333, 2);
    req_cyc = cyc;
    step();
    clear_inputs();
    run(0, 0, 50);
    check("post_rst_issue_lat", 32'(issue_cyc[0] - req_cyc), 1);

    // Spurious mem_resp while idle.
    force_resp = 1;
    step();
    check("spur_resp_ignored", {imem_resp, dmem_resp}, 2'b00);
    check("spur_mask", {mem_rmask, mem_wmask}, 8'h00);
    step();
    gnt_q.push_back(1);
    drive_d(32'h00005000, 4'hF, 4'h0, '0, 32'h77777777, 2);
    req_cyc = cyc;
    step();
    clear_inputs();
    run(0, 0, 50);
    check("post_spur_issue_lat", 32'(issue_cyc[1] - req_cyc), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one memory port between the fetch requester (imem) and the MEM/WB requester (dmem) in the pipelined core.
- Requesters use the same rmask/wmask/addr/wdata/rdata/resp convention the stages already use.
- Each requester's request is latched into a per-requester pending slot and issued downstream one at a time.
- The response is routed back to the owning requester.
- Fixed dmem priority, with a starvation guard for imem.

Parameters:
STARVE_LIMIT, 4, consecutive dmem grants with imem pending, after which the next grant goes to imem (range 1..15).

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  reset, synchronous, active-low
imem_addr  input  32  fetch address
imem_rmask  input  4  fetch read mask; nonzero for one cycle = request
imem_rdata  output  32  fetch read data, valid with imem_resp
imem_resp  output  1  fetch completion pulse
dmem_addr  input  32  data address
dmem_rmask  input  4  data read mask
dmem_wmask  input  4  data write mask
dmem_wdata  input  32  data write data
dmem_rdata  output  32  data read data, valid with dmem_resp
dmem_resp  output  1  data completion pulse
mem_addr  output  32  downstream address
mem_rmask  output  4  downstream read mask, one-cycle pulse per issue
mem_wmask  output  4  downstream write mask, one-cycle pulse per issue
mem_wdata  output  32  downstream write data
mem_rdata  input  32  downstream read data
mem_resp  input  1  downstream completion pulse

Behaviour:
- Request detection:
  - imem request = imem_rmask != 0.
  - dmem request = (dmem_rmask | dmem_wmask) != 0.
  - A request is captured into its pending slot (addr, masks, wdata) on the same edge.
- Protocol rule: a requester issues no new request until its resp.
  - A request arriving while that requester's slot is full or outstanding is dropped.
  - Simulation-only assertion fires on this.
- States:
  - IDLE: no transaction outstanding.
  - ISSUE: drive one pending request downstream for exactly one cycle.
  - WAIT_I / WAIT_D: outstanding imem / dmem transaction.
- Transitions:
  - IDLE→ISSUE when any slot is pending (a request captured at edge N gives an ISSUE cycle N+1).
  - ISSUE→WAIT_x.
  - WAIT_x→IDLE on mem_resp.
- Grant:
  - Both pending → dmem, unless starve_cnt == STARVE_LIMIT, in which case imem.
  - starve_cnt (4 b) increments on each dmem grant while imem is pending.
  - starve_cnt clears on any imem grant, and when imem has nothing pending.
- Downstream drive:
  - mem_rmask/mem_wmask are nonzero only in ISSUE; 0 otherwise.
  - mem_addr/mem_wdata are held from the granted slot through WAIT; don't-care in IDLE.
- Response:
  - In WAIT_x with mem_resp=1, x_resp=1 and x_rdata=mem_rdata in the same cycle (combinational pass-through).
  - The granted slot clears on that edge.
  - mem_resp in IDLE/ISSUE is ignored.
- Latency:
  - Idle port, lone request at cycle N: mem_*mask pulse at N+1, resp forwarded in the mem_resp cycle.
  - Minimum 2 cycles end to end.
- Simultaneous events:
  - A mem_resp for one requester and a new request from the other in the same cycle: both are honoured.
  - The new request is captured; next IDLE→ISSUE at the following edge.
- Reset (rst_n=0 at an edge):
  - State→IDLE; both slots cleared; starve_cnt=0.
  - All mem_*mask, imem_resp, dmem_resp = 0.
  - An outstanding transaction is abandoned; a late mem_resp after reset is ignored.
- Store-only requests return dmem_resp with dmem_rdata don't-care.

Optional Feature:
- ARB_RR_EN defined:
  - Fixed dmem priority and starve_cnt are replaced by a 1-bit last-grant register (reset: last=imem).
  - Both pending → grant the one not granted last.
  - STARVE_LIMIT is unused.
- ARB_RR_EN undefined: fixed dmem priority with the starvation guard as above.

Test Plan:
- Lone imem read addr 0x1ECEB000, mem_resp 3 cycles after issue, mem_rdata 0x00000013 → mem_rmask=0xF exactly one cycle; imem_resp=1 with imem_rdata=0x00000013; dmem_resp stays 0.
- imem and dmem (lw 0x1000) request in the same cycle → dmem issued first, imem issued in the ISSUE cycle after dmem's mem_resp; each resp routed only to its owner.
- dmem store addr 0x2004, wmask 0x3, wdata 0xDEADBEEF → mem_wmask=0x3, mem_wdata=0xDEADBEEF, mem_rmask=0; dmem_resp on mem_resp.
- Starvation, STARVE_LIMIT=2: imem pending, dmem re-requests immediately after every resp → grants D, D, I.
  - With ARB_RR_EN: grants D, I, D, I.
- rst_n=0 during WAIT_D, then mem_resp=1 the cycle after reset release → no dmem_resp/imem_resp, state IDLE, no mem mask pulses.
- mem_resp asserted spuriously in IDLE → no resp outputs, state unchanged.
